tw_mult_st2: RTL

TW_MULT_ST2 -- requirements
Module: tw_mult_st2

---
 rtl/tw_st2_pkg.sv | 31 +++
 rtl/tw_mult_st2_cmult.sv | 66 ++++++
 rtl/tw_mult_st2.sv | 83 ++++++++
 3 files changed

// File: rtl/tw_st2_pkg.sv
// Shared widths, constants and sample types for the stage-2 twiddle multiplier.
package tw_st2_pkg;
  localparam int DATA_W    = 12;
  localparam int TW_W      = 12;
  localparam int FRAME_LEN = 8;
  localparam logic [3:0] TW_BASE = 4'b1000;
  localparam int RND_C     = 1024;
  localparam int SHIFT     = 11;

  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int PROD_W = DATA_W + TW_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int MID_W  = SUM_W - SHIFT;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } tw_t;

  // Round half up, then floor-shift back to the sample scale.
  function automatic logic signed [MID_W-1:0] rnd_shift(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] r;
    r = s + SUM_W'(RND_C);
    return MID_W'(r >>> SHIFT);
  endfunction
endpackage

// File: rtl/tw_mult_st2_cmult.sv
// Complex multiply stages S1 (partial products) and S2 (round + fit to 12 bits).
// TW_MULT_SAT_EN selects saturation of the rounded result; otherwise it wraps.
module tw_cmult
  import tw_st2_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     i_vld,
  input  logic                     i_last,
  input  cplx_t                    i_x,
  input  tw_t                      i_w,
  output logic                     o_vld,
  output logic                     o_last,
  output logic signed [DATA_W-1:0] o_re,
  output logic signed [DATA_W-1:0] o_im
);
  localparam int STAGES = 2;
  localparam logic signed [MID_W-1:0] SAT_HI = MID_W'(2**(DATA_W-1) - 1);
  localparam logic signed [MID_W-1:0] SAT_LO = MID_W'(-(2**(DATA_W-1)));

  function automatic logic signed [DATA_W-1:0] fit(input logic signed [MID_W-1:0] m);
`ifdef TW_MULT_SAT_EN
    if (m > SAT_HI) return SAT_HI[DATA_W-1:0];
    if (m < SAT_LO) return SAT_LO[DATA_W-1:0];
    return m[DATA_W-1:0];
`else
    return m[DATA_W-1:0];
`endif
  endfunction

  logic [STAGES:1]          r_vld_pipe, r_last_pipe;
  logic signed [PROD_W-1:0] r_pp_rr, r_pp_ii, r_pp_ri, r_pp_ir;
  logic signed [SUM_W-1:0]  w_sum_re, w_sum_im;
  logic signed [DATA_W-1:0] r_re, r_im;

  assign w_sum_re = {r_pp_rr[PROD_W-1], r_pp_rr} - {r_pp_ii[PROD_W-1], r_pp_ii};
  assign w_sum_im = {r_pp_ri[PROD_W-1], r_pp_ri} + {r_pp_ir[PROD_W-1], r_pp_ir};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_pp_rr     <= '0;
      r_pp_ii     <= '0;
      r_pp_ri     <= '0;
      r_pp_ir     <= '0;
      r_re        <= '0;
      r_im        <= '0;
    end else if (en) begin
      r_vld_pipe  <= {r_vld_pipe[1], i_vld};
      r_last_pipe <= {r_last_pipe[1], i_last};
      r_pp_rr     <= $signed(i_x.re) * $signed(i_w.re);
      r_pp_ii     <= $signed(i_x.im) * $signed(i_w.im);
      r_pp_ri     <= $signed(i_x.re) * $signed(i_w.im);
      r_pp_ir     <= $signed(i_x.im) * $signed(i_w.re);
      r_re        <= fit(rnd_shift(w_sum_re));
      r_im        <= fit(rnd_shift(w_sum_im));
    end
  end

  assign o_vld  = r_vld_pipe[STAGES];
  assign o_last = r_last_pipe[STAGES];
  assign o_re   = r_re;
  assign o_im   = r_im;
endmodule

// File: rtl/tw_mult_st2.sv
// Stage-2 twiddle multiplier: sample indexing, twiddle fetch (S0) and the cmult pipeline.
// Define TW_MULT_SAT_EN to saturate results instead of wrapping.
module tw_mult_st2
  import tw_st2_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  input  logic                     in_last,
  output logic [3:0]               tw_addr,
  output logic                     tw_valid,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     out_last,
  output logic                     frame_err
);
  localparam logic [IDX_W-1:0] N_LAST = IDX_W'(FRAME_LEN - 1);

  logic             w_en, w_xfer, w_frame_bad;
  logic [3:0]       w_tw_addr_nxt, r_tw_addr;
  logic [IDX_W-1:0] r_n;
  cplx_t            r_s0;
  tw_t              w_tw;
  logic             r_s0_vld, r_s0_last, r_frame_err;

  assign w_en        = !(out_valid && !out_ready);
  assign in_ready    = rst && w_en;
  assign w_xfer      = in_valid && in_ready;
  assign w_frame_bad = in_last != (r_n == N_LAST);
  assign w_tw_addr_nxt = r_n[IDX_W-1] ? {TW_BASE[3:2], r_n[1:0]} : TW_BASE;

  // Address is live on the transfer cycle; otherwise the last issued one is held.
  assign tw_valid  = w_xfer;
  assign tw_addr   = w_xfer ? w_tw_addr_nxt : r_tw_addr;
  assign frame_err = r_frame_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_n         <= '0;
      r_tw_addr   <= '0;
      r_frame_err <= 1'b0;
      r_s0        <= '0;
      r_s0_vld    <= 1'b0;
      r_s0_last   <= 1'b0;
    end else begin
      r_frame_err <= w_xfer && w_frame_bad;
      if (w_xfer) begin
        r_n       <= w_frame_bad ? '0 : r_n + 1'b1;
        r_tw_addr <= w_tw_addr_nxt;
        r_s0.re   <= in_re;
        r_s0.im   <= in_im;
      end
      if (w_en) begin
        r_s0_vld  <= w_xfer;
        r_s0_last <= in_last;
      end
    end
  end

  assign w_tw.re = tw_re;
  assign w_tw.im = tw_im;

  tw_cmult u_cmult (
    .clk    (clk),
    .rst    (rst),
    .en     (w_en),
    .i_vld  (r_s0_vld),
    .i_last (r_s0_last),
    .i_x    (r_s0),
    .i_w    (w_tw),
    .o_vld  (out_valid),
    .o_last (out_last),
    .o_re   (out_re),
    .o_im   (out_im)
  );
endmodule
